// File: rtl/vga_stream_timing.sv
// Parametrised VGA sync/blank generator with incremental frame-buffer fetch and integer upscale.
// Build option: define VGA_TEST_PATTERN_EN to add an 8-bar colour source selected by test_pattern.
module vga_stream_timing #(
   parameter int H_VIEW       = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_VIEW       = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter bit SYNC_POL     = 1'b0,
   parameter int SCALE_SHIFT  = 0,
   parameter int READ_LATENCY = 1,
   parameter int ADDR_WIDTH   = 19
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [23:0]           data,
   input  logic                  test_pattern,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  h_sync,
   output logic                  v_sync,
   output logic                  blank_n,
   output logic [7:0]            red,
   output logic [7:0]            green,
   output logic [7:0]            blue,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;
   localparam int PIPE    = READ_LATENCY + 2;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int S       = 1 << SCALE_SHIFT;
   localparam int SRC_W   = H_VIEW >> SCALE_SHIFT;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_VIEW);
   localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VIEW - 1);
   localparam logic [HW-1:0] H_SS       = HW'(H_VIEW + H_FRONT);
   localparam logic [HW-1:0] H_SE       = HW'(H_VIEW + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS      = VW'(V_VIEW);
   localparam logic [VW-1:0] V_SS       = VW'(V_VIEW + V_FRONT);
   localparam logic [VW-1:0] V_SE       = VW'(V_VIEW + V_FRONT + V_SYNC);
   localparam logic [1:0]    SUB_LAST   = 2'(S - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SRC_W);

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } pixel_t;

   typedef struct packed {
      logic       vis;
      logic       hs;
      logic       vs;
      logic       fs;
`ifdef VGA_TEST_PATTERN_EN
      logic [2:0] bar;
`endif
   } ctl_t;

   logic [HW-1:0]         h_count;
   logic [VW-1:0]         v_count;
   logic                  h_end;
   logic                  v_end;
   logic                  visible;
   logic [ADDR_WIDTH-1:0] col;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [1:0]            h_sub;
   logic [1:0]            v_sub;
   ctl_t                  ctl0;
   ctl_t                  ctl_pipe [1:PIPE];
   pixel_t                pix_d;
   pixel_t                pix_q;

   assign h_end   = (h_count == H_LAST);
   assign v_end   = (v_count == V_LAST);
   assign visible = (h_count < H_VIS) && (v_count < V_VIS);

   // Stage 0: raster counters
   always_ff @(posedge clock) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_end) begin
         h_count <= '0;
         v_count <= v_end ? '0 : v_count + 1'b1;
      end else begin
         h_count <= h_count + 1'b1;
      end
   end

   // Source coordinates advance once per S output pixels/lines, so no multiplier is needed.
   always_ff @(posedge clock) begin
      if (reset) begin
         col      <= '0;
         h_sub    <= '0;
         row_base <= '0;
         v_sub    <= '0;
      end else begin
         if (h_count == H_VIS_LAST) begin
            col   <= '0;
            h_sub <= '0;
         end else if (visible) begin
            if (h_sub == SUB_LAST) begin
               h_sub <= '0;
               col   <= col + 1'b1;
            end else begin
               h_sub <= h_sub + 1'b1;
            end
         end
         if (h_end) begin
            if (v_end) begin
               row_base <= '0;
               v_sub    <= '0;
            end else if (v_count < V_VIS) begin
               if (v_sub == SUB_LAST) begin
                  v_sub    <= '0;
                  row_base <= row_base + ROW_STEP;
               end else begin
                  v_sub <= v_sub + 1'b1;
               end
            end
         end
      end
   end

   // Stage 1: address register, held through blanking
   always_ff @(posedge clock) begin
      if (reset)
         address <= '0;
      else if (visible)
         address <= row_base + col;
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_VIEW / 8;
   localparam int BW    = $clog2(BAR_W + 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [BW-1:0] bar_px;
   logic [2:0]    bar_idx;

   always_ff @(posedge clock) begin
      if (reset || h_end) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (visible) begin
         if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 1'b1;
         end else begin
            bar_px <= bar_px + 1'b1;
         end
      end
   end
`else
   logic unused_test_pattern;
   assign unused_test_pattern = test_pattern;
`endif

   always_comb begin
      ctl0     = '0;
      ctl0.vis = visible;
      ctl0.hs  = (h_count >= H_SS) && (h_count < H_SE);
      ctl0.vs  = (v_count >= V_SS) && (v_count < V_SE);
      ctl0.fs  = (h_count == '0) && (v_count == '0);
`ifdef VGA_TEST_PATTERN_EN
      ctl0.bar = bar_idx;
`endif
   end

   // Control delay line; stage k holds the pixel seen by the counters k cycles ago.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 1; k <= PIPE; k++)
            ctl_pipe[k] <= '0;
      end else begin
         ctl_pipe[1] <= ctl0;
         for (int k = 2; k <= PIPE; k++)
            ctl_pipe[k] <= ctl_pipe[k-1];
      end
   end

   always_comb begin
      pix_d = '0;
      if (ctl_pipe[PIPE-1].vis) begin
         pix_d = pixel_t'(data);
`ifdef VGA_TEST_PATTERN_EN
         if (test_pattern) begin
            pix_d.red   = {8{ctl_pipe[PIPE-1].bar[2]}};
            pix_d.green = {8{ctl_pipe[PIPE-1].bar[1]}};
            pix_d.blue  = {8{ctl_pipe[PIPE-1].bar[0]}};
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         pix_q <= '0;
      else
         pix_q <= pix_d;
   end

   assign red         = pix_q.red;
   assign green       = pix_q.green;
   assign blue        = pix_q.blue;
   assign blank_n     = ctl_pipe[PIPE].vis;
   assign frame_start = ctl_pipe[PIPE].fs;
   assign h_sync      = ctl_pipe[PIPE].hs ? SYNC_POL : ~SYNC_POL;
   assign v_sync      = ctl_pipe[PIPE].vs ? SYNC_POL : ~SYNC_POL;

endmodule
